// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes,
// controller FSM states and the hard-wired zero register number.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    // A producer only counts if it really writes a register other than $0.
    function automatic logic writes_reg(input logic wb, input logic [4:0] rw, input logic [4:0] src);
        return wb && (rw != REG_ZERO) && (rw == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational forwarding compare for one ALU operand; the EX/MEM producer is
// younger than MEM/WB, so it wins when both match.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_src,
    input  logic [4:0] mem_Rw,
    input  logic       mem_WB,
    input  logic [4:0] wb_Rw,
    input  logic       wb_WB,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (writes_reg(mem_WB, mem_Rw, ex_src)) begin
            sel = FWD_EXMEM;
        end else if (writes_reg(wb_WB, wb_Rw, ex_src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: stage enables, flushes,
// forwarding and memory-wait stalls. Optional statistics: HAZARD_STATS_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_ex_Rw,
    input  logic       i_ex_MemRead,
    input  logic [4:0] i_mem_Rw,
    input  logic       i_mem_WB,
    input  logic [4:0] i_wb_Rw,
    input  logic       i_wb_WB,
    input  logic       i_mem_req,
    input  logic       i_mem_ack,
    input  logic       i_branch_taken,
    output logic       o_pc_en,
    output logic       o_ifid_en,
    output logic       o_ifid_flush,
    output logic       o_idex_flush,
    output logic       o_exmem_en,
    output logic       o_memwb_WB,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_mem_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [15:0] o_flush_count
`endif
);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             load_use;
    logic             run_cycle;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    assign cnt_next = wait_cnt + 1'b1;
    assign load_use = i_ex_MemRead && (i_ex_Rw != REG_ZERO) &&
                      ((i_ex_Rw == i_id_rs) || (i_ex_Rw == i_id_rt));

    fwd_unit u_fwd_a (
        .ex_src (i_ex_rs),
        .mem_Rw (i_mem_Rw),
        .mem_WB (i_mem_WB),
        .wb_Rw  (i_wb_Rw),
        .wb_WB  (i_wb_WB),
        .sel    (sel_a)
    );

    fwd_unit u_fwd_b (
        .ex_src (i_ex_rt),
        .mem_Rw (i_mem_Rw),
        .mem_WB (i_mem_WB),
        .wb_Rw  (i_wb_Rw),
        .wb_WB  (i_wb_WB),
        .sel    (sel_b)
    );

    // wait_cnt holds the number of stalled cycles already spent on the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            o_mem_err <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_mem_req && !i_mem_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (cnt_next == CNT_W'(MEM_TIMEOUT)) begin
                        state     <= ST_ERR;
                        wait_cnt  <= cnt_next;
                        o_mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                default: begin
                    state <= ST_ERR;
                end
            endcase
        end
    end

    // A cycle in which the pipe may advance normally; otherwise memory/error freeze.
    always_comb begin
        run_cycle = 1'b0;
        case (state)
            ST_RUN:      run_cycle = !(i_mem_req && !i_mem_ack);
            ST_MEM_WAIT: run_cycle = i_mem_ack;
            default:     run_cycle = 1'b0;
        endcase
    end

    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_exmem_en   = 1'b0;
        o_memwb_WB   = 1'b0;
        o_fwd_a      = FWD_REG;
        o_fwd_b      = FWD_REG;
        if (i_rst_n) begin
            o_fwd_a = sel_a;
            o_fwd_b = sel_b;
            if (run_cycle) begin
                o_pc_en    = 1'b1;
                o_ifid_en  = 1'b1;
                o_exmem_en = 1'b1;
                o_memwb_WB = i_mem_WB;
                if (i_branch_taken) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (load_use) begin
                    o_pc_en      = 1'b0;
                    o_ifid_en    = 1'b0;
                    o_idex_flush = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
        end else begin
            if (!o_pc_en && (o_stall_cycles != '1)) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
            if (o_ifid_flush && (o_flush_count != '1)) begin
                o_flush_count <= o_flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic against a rule-level reference model. Build with HAZARD_STATS_EN for counters.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;

    logic       i_clk;
    logic       i_rst_n;
    logic [4:0] i_id_rs, i_id_rt, i_ex_rs, i_ex_rt, i_ex_Rw, i_mem_Rw, i_wb_Rw;
    logic       i_ex_MemRead, i_mem_WB, i_wb_WB, i_mem_req, i_mem_ack, i_branch_taken;
    logic       o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en, o_memwb_WB;
    logic [1:0] o_fwd_a, o_fwd_b;
    logic       o_mem_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] o_stall_cycles;
    logic [15:0] o_flush_count;
`endif

    wire [5:0] ctl = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en, o_memwb_WB};

    int vectors;
    int miscompares;

    // reference model state
    bit         mBusy;
    bit         mErr;
    int         mWaited;
    int         mStalls;
    int         mFlushes;
    bit         memHold;
    logic [5:0] expCtl;
    logic [1:0] expA, expB;
    logic       expErr;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_ex_rs        (i_ex_rs),
        .i_ex_rt        (i_ex_rt),
        .i_ex_Rw        (i_ex_Rw),
        .i_ex_MemRead   (i_ex_MemRead),
        .i_mem_Rw       (i_mem_Rw),
        .i_mem_WB       (i_mem_WB),
        .i_wb_Rw        (i_wb_Rw),
        .i_wb_WB        (i_wb_WB),
        .i_mem_req      (i_mem_req),
        .i_mem_ack      (i_mem_ack),
        .i_branch_taken (i_branch_taken),
        .o_pc_en        (o_pc_en),
        .o_ifid_en      (o_ifid_en),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_flush   (o_idex_flush),
        .o_exmem_en     (o_exmem_en),
        .o_memwb_WB     (o_memwb_WB),
        .o_fwd_a        (o_fwd_a),
        .o_fwd_b        (o_fwd_b),
        .o_mem_err      (o_mem_err)
`ifdef HAZARD_STATS_EN
        ,
        .o_stall_cycles (o_stall_cycles),
        .o_flush_count  (o_flush_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [1:0] fwdRef(input logic [4:0] src);
        if (i_mem_WB && i_mem_Rw != 5'd0 && i_mem_Rw == src) return 2'b01;
        if (i_wb_WB && i_wb_Rw != 5'd0 && i_wb_Rw == src) return 2'b10;
        return 2'b00;
    endfunction

    // Expected outputs for the current inputs, from the written rules.
    function automatic void model_eval();
        bit pc, ifid, ifl, idf, ex, wb, luse;
        expA   = fwdRef(i_ex_rs);
        expB   = fwdRef(i_ex_rt);
        expErr = mErr;
        memHold = mErr || (mBusy ? !i_mem_ack : (i_mem_req && !i_mem_ack));
        if (!i_rst_n) begin
            expCtl = 6'b0; expA = 2'b00; expB = 2'b00; expErr = 1'b0;
            return;
        end
        if (memHold) begin
            expCtl = 6'b0;
        end else begin
            pc = 1; ifid = 1; ifl = 0; idf = 0; ex = 1; wb = i_mem_WB;
            luse = i_ex_MemRead && i_ex_Rw != 5'd0 && (i_ex_Rw == i_id_rs || i_ex_Rw == i_id_rt);
            if (i_branch_taken) begin
                ifl = 1; idf = 1;
            end else if (luse) begin
                pc = 0; ifid = 0; idf = 1;
            end
            expCtl = {pc, ifid, ifl, idf, ex, wb};
        end
    endfunction

    // Advance the model across one rising clock edge.
    function automatic void model_advance();
        model_eval();
        if (!i_rst_n) return;
        if (!expCtl[5]) mStalls++;
        if (expCtl[3]) mFlushes++;
        if (!mErr) begin
            if (memHold) begin
                mBusy = 1;
                mWaited++;
                if (mWaited == MEM_TIMEOUT) mErr = 1;
            end else begin
                mBusy = 0;
                mWaited = 0;
            end
        end
    endfunction

    task automatic clear_inputs();
        i_id_rs = 0; i_id_rt = 0; i_ex_rs = 0; i_ex_rt = 0; i_ex_Rw = 0; i_mem_Rw = 0; i_wb_Rw = 0;
        i_ex_MemRead = 0; i_mem_WB = 0; i_wb_WB = 0; i_mem_req = 0; i_mem_ack = 0; i_branch_taken = 0;
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        mBusy = 0; mErr = 0; mWaited = 0; mStalls = 0; mFlushes = 0;
        #12;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats(input string tag);
        vectors++;
        if (o_stall_cycles !== 32'(mStalls)) begin
            miscompares++;
            $display("[TB] FAIL %s stall_cycles: got %0d want %0d", tag, o_stall_cycles, mStalls);
        end
        vectors++;
        if (o_flush_count !== 16'(mFlushes)) begin
            miscompares++;
            $display("[TB] FAIL %s flush_count: got %0d want %0d", tag, o_flush_count, mFlushes);
        end
    endtask
`endif

    task automatic test_reset();
        clear_inputs();
        i_mem_WB = 1; i_mem_Rw = 3; i_ex_rs = 3;
        i_rst_n = 1'b0;
        mBusy = 0; mErr = 0; mWaited = 0; mStalls = 0; mFlushes = 0;
        #3;
        vectors++;
        if (ctl !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset ctl: got %b want 000000", ctl);
        end
        vectors++;
        if ({o_fwd_a, o_fwd_b, o_mem_err} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset fwd/err: got %b%b%b want 00000", o_fwd_a, o_fwd_b, o_mem_err);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        clear_inputs();
        // enter a memory wait, then pull reset in the middle of it
        i_mem_req = 1;
        #3;
        next_cycle();
        next_cycle();
        i_rst_n = 1'b0;
        mBusy = 0; mErr = 0; mWaited = 0; mStalls = 0; mFlushes = 0;
        #2;
        vectors++;
        if (ctl !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait ctl: got %b want 000000", ctl);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_mem_req = 0;
        #3;
        vectors++;
        if (ctl !== 6'b110010) begin
            miscompares++;
            $display("[TB] FAIL reset_release ctl: got %b want 110010", ctl);
        end
        next_cycle();
`ifdef HAZARD_STATS_EN
        test_stats("reset");
`endif
    endtask

    task automatic test_load_use();
        clear_inputs();
        i_ex_MemRead = 1; i_ex_Rw = 8; i_id_rs = 8; i_id_rt = 2;
        #3;
        vectors++;
        if (ctl !== 6'b000110) begin
            miscompares++;
            $display("[TB] FAIL load_use ctl: got %b want 000110", ctl);
        end
        next_cycle();
        i_ex_MemRead = 0;
        #3;
        vectors++;
        if (ctl !== 6'b110010) begin
            miscompares++;
            $display("[TB] FAIL load_use_after ctl: got %b want 110010", ctl);
        end
        next_cycle();
        i_ex_MemRead = 1; i_ex_Rw = 0; i_id_rs = 0; i_id_rt = 0;
        #3;
        vectors++;
        if (ctl !== 6'b110010) begin
            miscompares++;
            $display("[TB] FAIL load_use_r0 ctl: got %b want 110010", ctl);
        end
        next_cycle();
        i_ex_Rw = 9; i_id_rs = 1; i_id_rt = 9;
        #3;
        vectors++;
        if (ctl !== 6'b000110) begin
            miscompares++;
            $display("[TB] FAIL load_use_rt ctl: got %b want 000110", ctl);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        i_mem_WB = 1; i_mem_Rw = 5; i_wb_WB = 1; i_wb_Rw = 5; i_ex_rs = 5; i_ex_rt = 5;
        #3;
        vectors++;
        if ({o_fwd_a, o_fwd_b} !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL fwd_both_match: got %b/%b want 01/01", o_fwd_a, o_fwd_b);
        end
        next_cycle();
        i_mem_WB = 0;
        #3;
        vectors++;
        if ({o_fwd_a, o_fwd_b} !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL fwd_memwb: got %b/%b want 10/10", o_fwd_a, o_fwd_b);
        end
        next_cycle();
        i_mem_WB = 1; i_mem_Rw = 0; i_wb_Rw = 0; i_ex_rs = 0; i_ex_rt = 0;
        #3;
        vectors++;
        if ({o_fwd_a, o_fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL fwd_r0: got %b/%b want 00/00", o_fwd_a, o_fwd_b);
        end
        next_cycle();
        i_mem_Rw = 4; i_wb_Rw = 7; i_ex_rs = 7; i_ex_rt = 4;
        #3;
        vectors++;
        if ({o_fwd_a, o_fwd_b} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL fwd_split: got %b/%b want 10/01", o_fwd_a, o_fwd_b);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        i_mem_WB = 1; i_mem_req = 1;
        for (int c = 0; c < 3; c++) begin
            #3;
            vectors++;
            if (ctl !== 6'b000000) begin
                miscompares++;
                $display("[TB] FAIL mem_wait cycle %0d ctl: got %b want 000000", c, ctl);
            end
            next_cycle();
        end
        i_mem_ack = 1;
        #3;
        vectors++;
        if (ctl !== 6'b110011) begin
            miscompares++;
            $display("[TB] FAIL mem_wait_ack ctl: got %b want 110011", ctl);
        end
        next_cycle();
        i_mem_req = 0; i_mem_ack = 0;
        #3;
        vectors++;
        if (ctl !== 6'b110011) begin
            miscompares++;
            $display("[TB] FAIL mem_wait_after ctl: got %b want 110011", ctl);
        end
        next_cycle();
        i_mem_req = 1; i_mem_ack = 1;
        #3;
        vectors++;
        if (ctl !== 6'b110011) begin
            miscompares++;
            $display("[TB] FAIL mem_zero_wait ctl: got %b want 110011", ctl);
        end
        next_cycle();
        i_mem_req = 0; i_mem_ack = 0;
    endtask

    task automatic test_branch_load_use();
        clear_inputs();
        i_branch_taken = 1; i_ex_MemRead = 1; i_ex_Rw = 8; i_id_rs = 8;
        #3;
        vectors++;
        if (ctl !== 6'b111110) begin
            miscompares++;
            $display("[TB] FAIL branch_load_use ctl: got %b want 111110", ctl);
        end
        next_cycle();
        i_ex_MemRead = 0; i_mem_req = 1;
        #3;
        vectors++;
        if (ctl !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL branch_during_stall ctl: got %b want 000000", ctl);
        end
        next_cycle();
        i_mem_ack = 1;
        #3;
        next_cycle();
        clear_inputs();
`ifdef HAZARD_STATS_EN
        test_stats("directed");
`endif
    endtask

    task automatic test_timeout();
        clear_inputs();
        i_mem_req = 1;
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            #3;
            if (c == MEM_TIMEOUT) begin
                vectors++;
                if (o_mem_err !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_early err: got %b want 0", o_mem_err);
                end
            end
            next_cycle();
        end
        for (int c = 0; c < 3; c++) begin
            i_mem_ack = (c == 1);
            i_mem_req = (c != 2);
            #3;
            vectors++;
            if ({o_mem_err, ctl} !== 7'b1000000) begin
                miscompares++;
                $display("[TB] FAIL timeout_err cycle %0d: got err=%b ctl=%b want err=1 ctl=000000", c, o_mem_err, ctl);
            end
            next_cycle();
        end
        i_mem_WB = 1; i_mem_Rw = 6; i_ex_rs = 6;
        #3;
        vectors++;
        if (o_fwd_a !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL fwd_in_err: got %b want 01", o_fwd_a);
        end
`ifdef HAZARD_STATS_EN
        model_advance();
        @(posedge i_clk); #1;
        test_stats("timeout");
`endif
        #2;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_mem_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_async_reset err: got %b want 0", o_mem_err);
        end
        mBusy = 0; mErr = 0; mWaited = 0; mStalls = 0; mFlushes = 0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int n = 0; n < 400; n++) begin
            i_id_rs = 5'($urandom_range(0, 3));
            i_id_rt = 5'($urandom_range(0, 3));
            i_ex_rs = 5'($urandom_range(0, 3));
            i_ex_rt = 5'($urandom_range(0, 3));
            i_ex_Rw = 5'($urandom_range(0, 3));
            i_mem_Rw = 5'($urandom_range(0, 3));
            i_wb_Rw = 5'($urandom_range(0, 3));
            i_ex_MemRead = 1'($urandom_range(0, 1));
            i_mem_WB = 1'($urandom_range(0, 1));
            i_wb_WB = 1'($urandom_range(0, 1));
            i_branch_taken = ($urandom_range(0, 3) == 0);
            if (mBusy) begin
                i_mem_req = 1;
                i_mem_ack = ($urandom_range(0, 2) == 0) || (mWaited >= 10);
                if (i_mem_ack) begin
                    i_branch_taken = 0;
                    i_ex_MemRead = 0;
                end
            end else begin
                i_mem_req = ($urandom_range(0, 4) == 0);
                i_mem_ack = i_mem_req && ($urandom_range(0, 1) == 0);
            end
            #3;
            model_eval();
            vectors++;
            if (ctl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d] ctl: got %b want %b", n, ctl, expCtl);
            end
            vectors++;
            if ({o_fwd_a, o_fwd_b} !== {expA, expB}) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d] fwd: got %b/%b want %b/%b", n, o_fwd_a, o_fwd_b, expA, expB);
            end
            vectors++;
            if (o_mem_err !== expErr) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d] err: got %b want %b", n, o_mem_err, expErr);
            end
            next_cycle();
        end
`ifdef HAZARD_STATS_EN
        test_stats("random");
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forwarding();
        test_mem_wait();
        test_branch_load_use();
        test_timeout();
        do_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates per-stage enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates forwarding selects for both ALU operands.
- Stalls the whole pipe during multi-cycle data-memory accesses.
- Injects a write-back bubble into memory_writeback by forcing its i_WB low while data is not yet valid.

Parameters:
MEM_TIMEOUT, 16, max cycles a data-memory access may wait for i_mem_ack before o_mem_err is raised
CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_id_rs  in  5  rs of instruction in ID
i_id_rt  in  5  rt of instruction in ID
i_ex_rs  in  5  rs of instruction in EX
i_ex_rt  in  5  rt of instruction in EX
i_ex_Rw  in  5  destination of instruction in EX
i_ex_MemRead  in  1  EX instruction is a load
i_mem_Rw  in  5  destination in MEM
i_mem_WB  in  1  MEM instruction writes register file
i_wb_Rw  in  5  destination in WB (memory_writeback o_Rw)
i_wb_WB  in  1  WB instruction writes register file (memory_writeback o_WB)
i_mem_req  in  1  MEM stage instruction accesses data memory
i_mem_ack  in  1  data memory access complete
i_branch_taken  in  1  branch/jump resolved taken in EX
o_pc_en  out  1  PC update enable
o_ifid_en  out  1  IF/ID load enable
o_ifid_flush  out  1  IF/ID clear
o_idex_flush  out  1  ID/EX clear (bubble)
o_exmem_en  out  1  EX/MEM load enable
o_memwb_WB  out  1  gates i_WB of MEM/WB register (0 = bubble)
o_fwd_a  out  2  operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
o_fwd_b  out  2  operand B select, same encoding
o_mem_err  out  1  sticky memory-timeout error

Behaviour:
- Clock and reset:
  - Single clock i_clk, rising edge.
  - Reset asynchronous, active-low on i_rst_n. This is fixed.
- Values while i_rst_n=0:
  - state=RUN, wait counter=0, o_mem_err=0.
  - All enables=0, all flushes=0, o_memwb_WB=0, o_fwd_a/b=00.
- FSM states: RUN, MEM_WAIT, ERR.
- RUN:
  - Default outputs: all enables=1, flushes=0, o_memwb_WB=i_mem_WB.
  - If i_mem_req=1 and i_mem_ack=0: go to MEM_WAIT. Same cycle: o_pc_en=o_ifid_en=o_exmem_en=0, o_memwb_WB=0.
  - If i_mem_req=1 and i_mem_ack=1: zero-wait access, stay in RUN.
- MEM_WAIT:
  - Hold the stall outputs listed above.
  - Counter increments each cycle.
  - On i_mem_ack=1: return to RUN, counter cleared. Outputs that cycle are the RUN defaults.
  - If the counter reaches MEM_TIMEOUT without ack: go to ERR and set o_mem_err.
- ERR:
  - Terminal until reset.
  - pc/ifid/exmem enables=0, o_memwb_WB=0.
- Load-use hazard (RUN only):
  - Condition: i_ex_MemRead=1, i_ex_Rw!=0, and i_ex_Rw equals i_id_rs or i_id_rt.
  - Action: o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for exactly one cycle. Combinational; the hazard clears once the load moves to MEM.
- Branch taken (RUN only):
  - o_ifid_flush=1 and o_idex_flush=1.
  - Branch has priority over load-use: o_pc_en=1, o_ifid_en=1.
- Priority: ERR > MEM_WAIT/memory stall > branch > load-use.
  - A branch or load-use arriving during a memory stall is ignored. The inputs stay held because upstream registers are frozen, so the event is re-evaluated after the stall.
- Forwarding (combinational, active in all states except reset):
  - A = 01 if i_mem_WB, i_mem_Rw!=0 and i_mem_Rw==i_ex_rs.
  - Else A = 10 if i_wb_WB, i_wb_Rw!=0 and i_wb_Rw==i_ex_rs.
  - Else A = 00.
  - B is identical using i_ex_rt.
  - The EX/MEM match wins when both match.
- Register $0 never forwards and never causes a stall.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, error cleared.

Optional Feature:
HAZARD_STATS_EN
- Defined:
  - Adds outputs o_stall_cycles[31:0] and o_flush_count[15:0].
  - o_stall_cycles counts every cycle with o_pc_en=0 while i_rst_n=1.
  - o_flush_count counts cycles with o_ifid_flush=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - forwarding select constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - FSM state encoding;
  - REG_ZERO=5'd0.
- One natural sub-module: fwd_unit, the pure combinational forwarding compare, instantiated once for A and once for B.

Test Plan:
- Load-use: EX lw (i_ex_MemRead=1, i_ex_Rw=8), i_id_rs=8 -> one cycle with o_pc_en=0, o_ifid_en=0, o_idex_flush=1; next cycle with i_ex_MemRead=0 -> all enables 1.
- Forwarding: i_mem_WB=1, i_mem_Rw=5, i_wb_WB=1, i_wb_Rw=5, i_ex_rs=5, i_ex_rt=5 -> o_fwd_a=01, o_fwd_b=01; with i_mem_WB=0 -> both 10; with Rw=0 -> both 00.
- Memory wait: i_mem_req=1, ack after 3 cycles -> 3 cycles of o_pc_en=0 and o_memwb_WB=0, then RUN with o_memwb_WB=i_mem_WB.
- Timeout: i_mem_req=1, no ack for 16 cycles -> o_mem_err=1 and stays 1; assert i_rst_n=0 -> o_mem_err=0 asynchronously.
- Branch plus load-use in the same cycle -> o_ifid_flush=1, o_idex_flush=1, o_pc_en=1.
- HAZARD_STATS_EN build: the first four scenarios in sequence -> o_stall_cycles equals the total cycles with o_pc_en=0; o_flush_count increments once per branch.
